// File: rtl/wait_arbiter_if.sv
// Client/downstream signal bundle for wait_arbiter.
// slave is the arbiter side; master is the client and timer side.
interface wait_arbiter_if #(
  parameter int unsigned CW = 32
);
  logic [3:0]    req;
  logic [CW-1:0] cycles0;
  logic [CW-1:0] cycles1;
  logic [CW-1:0] cycles2;
  logic [CW-1:0] cycles3;
  logic [3:0]    ack;
  logic          wreq;
  logic [CW-1:0] wcycles;
  logic          wack;
  logic          busy;
  logic [1:0]    grant;
  logic          err;

  modport slave (
    input  req, cycles0, cycles1, cycles2, cycles3, wack,
    output ack, wreq, wcycles, busy, grant, err
  );

  modport master (
    output req, cycles0, cycles1, cycles2, cycles3, wack,
    input  ack, wreq, wcycles, busy, grant, err
  );
endinterface

// File: rtl/wait_arbiter.sv
// Four-client round-robin arbiter in front of a single downstream wait timer.
// One request is in flight at a time; wack pulses outside WAIT latch a sticky error.
module wait_arbiter #(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  wait_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e        r_state;
  logic [3:0]    r_ack;
  logic          r_wreq;
  logic [CW-1:0] r_wcycles;
  logic [1:0]    r_grant;
  logic [1:0]    r_last_grant;
  logic          r_err;

  state_e        w_state_nxt;
  logic [3:0]    w_ack_nxt;
  logic          w_wreq_nxt;
  logic [CW-1:0] w_wcycles_nxt;
  logic [1:0]    w_grant_nxt;
  logic [1:0]    w_last_grant_nxt;
  logic          w_err_nxt;

  logic          w_pick_valid;
  logic [1:0]    w_pick;
  logic [1:0]    w_idx;
  logic [CW-1:0] w_sel_cycles;

  // Search starts one past the last grant; the offset 4 wraps back to last_grant itself.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = r_last_grant;
    w_idx        = '0;
    for (int unsigned k = 1; k < 5; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_pick_valid && bus.req[w_idx]) begin
        w_pick_valid = 1'b1;
        w_pick       = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_cycles = bus.cycles0;
    unique case (w_pick)
      2'd0: w_sel_cycles = bus.cycles0;
      2'd1: w_sel_cycles = bus.cycles1;
      2'd2: w_sel_cycles = bus.cycles2;
      2'd3: w_sel_cycles = bus.cycles3;
      default: w_sel_cycles = bus.cycles0;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ack_nxt        = r_ack;
    w_wreq_nxt       = r_wreq;
    w_wcycles_nxt    = r_wcycles;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_err_nxt        = r_err;
    unique case (r_state)
      StIdle: begin
        if (bus.wack) w_err_nxt = 1'b1;
        if (w_pick_valid) begin
          w_state_nxt      = StWait;
          w_wreq_nxt       = 1'b1;
          w_wcycles_nxt    = w_sel_cycles;
          w_grant_nxt      = w_pick;
          w_last_grant_nxt = w_pick;
        end
      end
      StWait: begin
        w_wreq_nxt = 1'b0;
        if (bus.wack) begin
          w_ack_nxt   = 4'b0001 << r_grant;
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_ack_nxt   = 4'b0000;
        w_state_nxt = StIdle;
        if (bus.wack) w_err_nxt = 1'b1;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // last_grant resets to 3 so client 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_ack        <= 4'b0000;
      r_wreq       <= 1'b0;
      r_wcycles    <= '0;
      r_grant      <= 2'd0;
      r_last_grant <= 2'd3;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ack        <= w_ack_nxt;
      r_wreq       <= w_wreq_nxt;
      r_wcycles    <= w_wcycles_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign bus.ack     = r_ack;
  assign bus.wreq    = r_wreq;
  assign bus.wcycles = r_wcycles;
  assign bus.grant   = r_grant;
  assign bus.err     = r_err;
  assign bus.busy    = (r_state != StIdle);

endmodule

// File: tb/tb_wait_arbiter.sv
// Directed bench for wait_arbiter with a behavioural downstream wait timer.
module tb_wait_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tm_wack = 1'b0;
  logic spur_wack = 1'b0;
  logic tm_busy = 1'b0;
  int   tm_cnt = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  wait_arbiter_if #(.CW(32)) u_bus ();

  wait_arbiter #(.CW(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  always #5 clk = ~clk;

  assign u_bus.wack = tm_wack | spur_wack;

  // Downstream timer: accepts wreq when idle, pulses wack cycles+2 cycles after the wreq cycle.
  always @(negedge clk) begin
    if (rst) begin
      tm_busy = 1'b0;
      tm_cnt  = 0;
      tm_wack = 1'b0;
    end else begin
      tm_wack = 1'b0;
      if (tm_busy) begin
        tm_cnt = tm_cnt - 1;
        if (tm_cnt == 0) begin
          tm_wack = 1'b1;
          tm_busy = 1'b0;
        end
      end else if (u_bus.wreq === 1'b1) begin
        tm_busy = 1'b1;
        tm_cnt  = int'(u_bus.wcycles) + 2;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_wreq(input string tag);
    int n = 0;
    while (u_bus.wreq !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, " wreq timeout"}, 64'(u_bus.wreq), 64'd1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (u_bus.ack === 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, " ack timeout"}, 64'(|u_bus.ack), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (u_bus.busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, " idle timeout"}, 64'(u_bus.busy), 64'd0);
  endtask

  task automatic do_reset();
    u_bus.req = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] cyc_tab [4] = '{32'd1, 32'd2, 32'd3, 32'd0};

  initial begin
    int t;
    int last_done;
    u_bus.req     = 4'b0000;
    u_bus.cycles0 = '0;
    u_bus.cycles1 = '0;
    u_bus.cycles2 = '0;
    u_bus.cycles3 = '0;
    tick();
    tick();
    check("rst ack", 64'(u_bus.ack), 64'd0);
    check("rst wreq", 64'(u_bus.wreq), 64'd0);
    check("rst wcycles", 64'(u_bus.wcycles), 64'd0);
    check("rst grant", 64'(u_bus.grant), 64'd0);
    check("rst err", 64'(u_bus.err), 64'd0);
    check("rst busy", 64'(u_bus.busy), 64'd0);

    // Single request with an absolute cycle timeline.
    rst = 1'b0;
    u_bus.cycles0 = 32'd5;
    u_bus.req = 4'b0001;
    cyc = 0;
    tick();
    check("single wreq", 64'(u_bus.wreq), 64'd1);
    check("single wcycles", 64'(u_bus.wcycles), 64'd5);
    check("single grant", 64'(u_bus.grant), 64'd0);
    check("single busy", 64'(u_bus.busy), 64'd1);
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (c == 2) check("single wreq pulse", 64'(u_bus.wreq), 64'd0);
      if (c == 9) begin
        check("single ack c9", 64'(u_bus.ack), 64'd1);
        u_bus.req = 4'b0000;
      end else begin
        check($sformatf("single ack c%0d", c), 64'(u_bus.ack), 64'd0);
      end
      if (c == 10) check("single busy c10", 64'(u_bus.busy), 64'd0);
    end

    // Round robin with all clients re-requesting.
    do_reset();
    u_bus.cycles0 = cyc_tab[0];
    u_bus.cycles1 = cyc_tab[1];
    u_bus.cycles2 = cyc_tab[2];
    u_bus.cycles3 = cyc_tab[3];
    u_bus.req = 4'b1111;
    last_done = 0;
    for (int k = 0; k < 5; k++) begin
      wait_wreq($sformatf("rr%0d", k));
      check($sformatf("rr%0d grant", k), 64'(u_bus.grant), 64'(k % 4));
      check($sformatf("rr%0d wcycles", k), 64'(u_bus.wcycles), 64'(cyc_tab[k % 4]));
      if (k > 0) check($sformatf("rr%0d spacing", k), 64'(cyc - last_done), 64'd2);
      wait_ack($sformatf("rr%0d", k));
      check($sformatf("rr%0d ack", k), 64'(u_bus.ack), 64'(4'b0001 << (k % 4)));
      last_done = cyc;
      if (k == 4) u_bus.req = 4'b0000;
    end
    wait_idle("rr");
    check("rr err", 64'(u_bus.err), 64'd0);

    // Zero wait count.
    do_reset();
    u_bus.cycles2 = 32'd0;
    u_bus.req = 4'b0100;
    wait_wreq("zero");
    t = cyc;
    check("zero wcycles", 64'(u_bus.wcycles), 64'd0);
    check("zero grant", 64'(u_bus.grant), 64'd2);
    wait_ack("zero");
    check("zero latency", 64'(cyc - t), 64'd3);
    check("zero ack", 64'(u_bus.ack), 64'h4);
    u_bus.req = 4'b0000;
    wait_idle("zero");

    // Client 3 arrives while client 1 is waiting.
    u_bus.cycles1 = 32'd4;
    u_bus.req = 4'b0010;
    wait_wreq("late1");
    check("late1 grant", 64'(u_bus.grant), 64'd1);
    tick();
    u_bus.cycles3 = 32'd2;
    u_bus.req = 4'b1010;
    tick();
    check("late1 grant held", 64'(u_bus.grant), 64'd1);
    check("late1 busy", 64'(u_bus.busy), 64'd1);
    wait_ack("late1");
    check("late1 ack", 64'(u_bus.ack), 64'h2);
    u_bus.req = 4'b1000;
    t = cyc;
    wait_wreq("late3");
    check("late3 spacing", 64'(cyc - t), 64'd2);
    check("late3 grant", 64'(u_bus.grant), 64'd3);
    check("late3 wcycles", 64'(u_bus.wcycles), 64'd2);
    wait_ack("late3");
    check("late3 ack", 64'(u_bus.ack), 64'h8);
    u_bus.req = 4'b0000;
    wait_idle("late");

    // Reset during WAIT abandons the request.
    u_bus.cycles2 = 32'd10;
    u_bus.req = 4'b0100;
    wait_wreq("mid");
    tick();
    tick();
    check("mid busy pre", 64'(u_bus.busy), 64'd1);
    rst = 1'b1;
    u_bus.req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("mid rst%0d ack", i), 64'(u_bus.ack), 64'd0);
      check($sformatf("mid rst%0d wreq", i), 64'(u_bus.wreq), 64'd0);
      check($sformatf("mid rst%0d busy", i), 64'(u_bus.busy), 64'd0);
      check($sformatf("mid rst%0d grant", i), 64'(u_bus.grant), 64'd0);
    end
    rst = 1'b0;
    u_bus.cycles0 = 32'd3;
    u_bus.cycles1 = 32'd3;
    u_bus.req = 4'b0011;
    wait_wreq("post0");
    check("post0 grant", 64'(u_bus.grant), 64'd0);
    wait_ack("post0");
    check("post0 ack", 64'(u_bus.ack), 64'h1);
    u_bus.req = 4'b0010;
    wait_wreq("post1");
    check("post1 grant", 64'(u_bus.grant), 64'd1);
    wait_ack("post1");
    check("post1 ack", 64'(u_bus.ack), 64'h2);
    u_bus.req = 4'b0000;
    wait_idle("post");

    // Spurious wack while idle.
    check("spur err pre", 64'(u_bus.err), 64'd0);
    spur_wack = 1'b1;
    tick();
    spur_wack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("spur%0d err", i), 64'(u_bus.err), 64'd1);
      check($sformatf("spur%0d busy", i), 64'(u_bus.busy), 64'd0);
      check($sformatf("spur%0d ack", i), 64'(u_bus.ack), 64'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
